// File: rtl/sprite_plotter_if.sv
// Sprite request / framebuffer pixel bundle between a game controller and the plotter.
interface sprite_plotter_if;
    logic        start;
    logic [24:0] shape;
    logic [7:0]  tile_x;
    logic [6:0]  tile_y;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, shape, tile_x, tile_y,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  start, shape, tile_x, tile_y,
        output vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Erases the previously drawn tile, then plots a 5x5 sprite one pixel per clock.
//
// state | meaning
// IDLE  | waiting for an in-range start
// ERASE | 25 background pixels over the previous tile
// DRAW  | 25 sprite pixels over the latched tile
// DONE  | one-cycle completion pulse
module sprite_plotter #(
    parameter int         TILE      = 5,
    parameter logic [2:0] FG_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input logic         clock,
    input logic         reset,
    sprite_plotter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [7:0] TILE_X = 8'(TILE);
    localparam logic [6:0] TILE_Y = 7'(TILE);

    state_t      state, state_nxt;
    logic [2:0]  row, row_nxt, col, col_nxt;
    logic [24:0] shape_q, shape_nxt;
    logic [7:0]  tile_x_q, tile_x_nxt, prev_x, prev_x_nxt;
    logic [6:0]  tile_y_q, tile_y_nxt, prev_y, prev_y_nxt;
    logic        has_prev, has_prev_nxt;
    logic [7:0]  vga_x_q, vga_x_nxt;
    logic [6:0]  vga_y_q, vga_y_nxt;
    logic [2:0]  colour_q, colour_nxt;
    logic        plot_q, plot_nxt, busy_q, busy_nxt, done_q, done_nxt;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [4:0]  bit_idx;
    logic        last_pix;

    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        shape_nxt    = shape_q;
        tile_x_nxt   = tile_x_q;
        tile_y_nxt   = tile_y_q;
        prev_x_nxt   = prev_x;
        prev_y_nxt   = prev_y;
        has_prev_nxt = has_prev;
        vga_x_nxt    = vga_x_q;
        vga_y_nxt    = vga_y_q;
        colour_nxt   = colour_q;
        last_pix     = (row == 3'd4) && (col == 3'd4);

        case (state)
            IDLE: begin
                if (bus.start && (bus.tile_x <= 8'd26) && (bus.tile_y <= 7'd23)) begin
                    shape_nxt  = bus.shape;
                    tile_x_nxt = bus.tile_x;
                    tile_y_nxt = bus.tile_y;
                    state_nxt  = has_prev ? ERASE : DRAW;
                    row_nxt    = 3'd0;
                    col_nxt    = 3'd0;
                end
            end
            ERASE, DRAW: begin
                if (last_pix) begin
                    row_nxt = 3'd0;
                    col_nxt = 3'd0;
                    if (state == ERASE) begin
                        state_nxt = DRAW;
                    end else begin
                        state_nxt    = DONE;
                        prev_x_nxt   = tile_x_q;
                        prev_y_nxt   = tile_y_q;
                        has_prev_nxt = 1'b1;
                    end
                end else if (col == 3'd4) begin
                    col_nxt = 3'd0;
                    row_nxt = row + 3'd1;
                end else begin
                    col_nxt = col + 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are derived from the next state so the registered pixel lines up with its counter.
        base_x   = (state_nxt == ERASE) ? prev_x_nxt : tile_x_nxt;
        base_y   = (state_nxt == ERASE) ? prev_y_nxt : tile_y_nxt;
        bit_idx  = 5'd24 - ({2'b00, row_nxt} * 5'd5 + {2'b00, col_nxt});
        plot_nxt = (state_nxt == ERASE) || (state_nxt == DRAW);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        if (plot_nxt) begin
            vga_x_nxt  = base_x * TILE_X + {5'b00000, col_nxt};
            vga_y_nxt  = base_y * TILE_Y + {4'b0000, row_nxt};
            colour_nxt = ((state_nxt == DRAW) && shape_nxt[bit_idx]) ? FG_COLOUR : BG_COLOUR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            row      <= 3'd0;
            col      <= 3'd0;
            shape_q  <= 25'd0;
            tile_x_q <= 8'd0;
            tile_y_q <= 7'd0;
            prev_x   <= 8'd0;
            prev_y   <= 7'd0;
            has_prev <= 1'b0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 7'd0;
            colour_q <= BG_COLOUR;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            shape_q  <= shape_nxt;
            tile_x_q <= tile_x_nxt;
            tile_y_q <= tile_y_nxt;
            prev_x   <= prev_x_nxt;
            prev_y   <= prev_y_nxt;
            has_prev <= has_prev_nxt;
            vga_x_q  <= vga_x_nxt;
            vga_y_q  <= vga_y_nxt;
            colour_q <= colour_nxt;
            plot_q   <= plot_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    assign bus.vga_x  = vga_x_q;
    assign bus.vga_y  = vga_y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised scoreboard bench for sprite_plotter: stimulus pushes expected pixels, a monitor checks them.
module tb_sprite_plotter;
    logic clock;
    logic reset;

    sprite_plotter_if bus();

    sprite_plotter #(.TILE(5), .FG_COLOUR(3'b110), .BG_COLOUR(3'b000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t exp_q[$];
    int   done_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   busy_lo     = 1;
    int   busy_hi     = 0;
    bit   mon_en      = 0;
    bit   has_prev    = 0;
    int   prev_x      = 0;
    int   prev_y      = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle the plot/done/busy lines are compared with what the scoreboard holds.
    always @(negedge clock) begin
        if (mon_en) begin
            bit   exp_plot;
            bit   exp_done;
            pix_t e;
            exp_plot = (exp_q.size() > 0) && (exp_q[0].t == cyc);
            chk("plot", int'(bus.plot), int'(exp_plot));
            if (exp_plot) begin
                e = exp_q.pop_front();
                chk("vga_x", int'(bus.vga_x), e.x);
                chk("vga_y", int'(bus.vga_y), e.y);
                chk("colour", int'(bus.colour), e.c);
            end
            exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            chk("done", int'(bus.done), int'(exp_done));
            if (exp_done) void'(done_q.pop_front());
            chk("busy", int'(bus.busy), int'((cyc >= busy_lo) && (cyc <= busy_hi)));
        end
    end

    // Called just after a rising edge with the DUT idle. abort_k > 0 asserts reset during the abort_k-th plot.
    task automatic issue(input logic [24:0] shp, input int tx, input int ty,
                         input bit noise, input int abort_k);
        int a;
        int len;
        int k;
        bit ok;
        ok = (tx <= 26) && (ty <= 23);
        bus.start  = 1'b1;
        bus.shape  = shp;
        bus.tile_x = 8'(tx);
        bus.tile_y = 7'(ty);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        a = cyc;
        if (!ok) begin
            repeat (4) begin
                @(posedge clock);
                #1;
            end
            return;
        end
        len = has_prev ? 50 : 25;
        k = 0;
        if (has_prev) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    exp_q.push_back('{x: prev_x * 5 + c, y: prev_y * 5 + r, c: 0, t: a + k});
                    k++;
                end
            end
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                exp_q.push_back('{x: tx * 5 + c, y: ty * 5 + r,
                                  c: shp[24 - (r * 5 + c)] ? 6 : 0, t: a + k});
                k++;
            end
        end
        done_q.push_back(a + len);
        busy_lo  = a;
        busy_hi  = a + len;
        has_prev = 1'b1;
        prev_x   = tx;
        prev_y   = ty;
        while (cyc <= a + len) begin
            if (abort_k > 0 && cyc == a + abort_k - 1) begin
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                exp_q.delete();
                done_q.delete();
                busy_lo  = 1;
                busy_hi  = 0;
                has_prev = 1'b0;
                chk("reset_plot", int'(bus.plot), 0);
                chk("reset_busy", int'(bus.busy), 0);
                chk("reset_done", int'(bus.done), 0);
                break;
            end
            if (noise) begin
                bus.start  = ($urandom_range(0, 2) == 0);
                bus.shape  = 25'($urandom);
                bus.tile_x = 8'($urandom_range(0, 26));
                bus.tile_y = 7'($urandom_range(0, 23));
            end
            @(posedge clock);
            #1;
        end
        bus.start = 1'b0;
    endtask

    logic [24:0] shp_a;
    logic [24:0] shp_ones;

    initial begin
        shp_a      = 25'b0111011111110001111101110;
        shp_ones   = '1;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.shape  = '0;
        bus.tile_x = '0;
        bus.tile_y = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_vga_x", int'(bus.vga_x), 0);
        chk("rst_vga_y", int'(bus.vga_y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        mon_en = 1'b1;
        @(posedge clock);
        #1;

        issue(shp_a, 0, 0, 1'b0, 0);
        issue(shp_a, 1, 0, 1'b0, 0);
        issue(shp_ones, 26, 23, 1'b0, 0);
        issue(shp_a, 3, 7, 1'b1, 0);
        issue(shp_a, 27, 5, 1'b0, 0);
        issue(shp_ones, 4, 24, 1'b0, 0);
        issue(25'($urandom), 12, 9, 1'b0, 0);
        issue(shp_a, 20, 10, 1'b0, 10);
        issue(shp_a, 2, 2, 1'b0, 0);
        for (int i = 0; i < 24; i++) begin
            issue(25'($urandom), $urandom_range(0, 28), $urandom_range(0, 25),
                  1'($urandom_range(0, 1)), 0);
        end
        repeat (3) @(posedge clock);
        #1;
        chk("pixels_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
